// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_pkg;
  localparam int unsigned PW_DEFAULT = 3;
  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when both requesters contend.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = (ptr == REQ_A) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // ptr names the requester favoured at the next contested cycle
  always_ff @(posedge clk) begin
    if (reset)                     ptr <= REQ_A;
    else if (en && req == 2'b11)   ptr <= gnt[0] ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Register-file write-port arbiter: clears the file after reset/start, then
// round-robins ALU (A) and load (B) writebacks. Optional RF_ARB_STALL_CNT_EN adds stall_cnt.
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned PW = PW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [PW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [PW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_wr_en,
  output logic [PW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          busy,
  output logic          last_grant_b
`ifdef RF_ARB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  rf_state_e     state, state_nx;
  logic [PW-1:0] cnt, cnt_nx;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          a_hs, b_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        if (start)          cnt_nx = '0;
        else if (cnt == '1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else            cnt_nx = cnt + 1'b1;
      end
      RUN: begin
        if (start) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy   = (state == CLEAR);
  assign arb_en = (state == RUN) && !start;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({b_valid, a_valid}),
    .gnt   (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign a_hs    = a_valid & a_ready;
  assign b_hs    = b_valid & b_ready;

  // addr/data hold their last value on idle cycles; only rf_wr_en qualifies them
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      last_grant_b <= 1'b0;
    end else if (state == CLEAR) begin
      rf_wr_en     <= 1'b1;
      rf_wr_addr   <= cnt;
      rf_wr_data   <= '0;
    end else if (a_hs) begin
      rf_wr_en     <= 1'b1;
      rf_wr_addr   <= a_addr;
      rf_wr_data   <= a_data;
      last_grant_b <= 1'b0;
    end else if (b_hs) begin
      rf_wr_en     <= 1'b1;
      rf_wr_addr   <= b_addr;
      rf_wr_data   <= b_data;
      last_grant_b <= 1'b1;
    end else begin
      rf_wr_en     <= 1'b0;
    end
  end

`ifdef RF_ARB_STALL_CNT_EN
  logic stall_now;
  assign stall_now = (a_valid & ~a_ready) | (b_valid & ~b_ready);

  always_ff @(posedge clk) begin
    if (reset || start)                   stall_cnt <= '0;
    else if (stall_now && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
